inst_encoder: RTL

- Packs decoded instruction fields (format, opcode, registers, functs, 32-bit immediate) into a 32-bit RV32I instruction word.
- Range- and alignment-checks the immediate for its format.
- Writes accepted words sequentially into instruction memory over a write/ack handshake.
- Sits between the test/program-loader front end and instruction memory. It is the encode-side inverse of the decode-side `immediate_generator`.

---
 rtl/inst_encoder_pkg.sv | 49 ++++
 rtl/inst_encoder_if.sv | 42 ++++
 rtl/inst_encoder_imm_pack.sv | 62 ++++++
 rtl/inst_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// enc_pkg: shared types and constants for the instruction encoder slice.
//   fmt_t   - instruction format selector (R, I, S, B, U, J; 6/7 illegal)
//   err_t   - reject reason, ordered so the numeric code matches err_code
//   state_t - encoder FSM states
//   RV32I base opcodes used by the program loader
//   upper_uniform() - sign-extension range helper for immediates
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_BADFMT   = 2'd3
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;

  // True when bits [31:lsb] of v are all equal, i.e. v is a valid
  // sign extension of its low lsb+1 bits.
  function automatic logic upper_uniform(input logic [31:0] v, input logic [4:0] lsb);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << lsb;
    return ((v & mask) == mask) || ((v & mask) == 32'h0000_0000);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: request, control and instruction-memory write bus of the
// encoder.
//   slave  - encoder view: takes the request fields, restart and mem_ack;
//            drives in_ready, the memory write port and the status flags
//   master - front-end / memory-side view, the mirror image
interface inst_encoder_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              restart;
  logic              mem_we;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              err;
  logic [1:0]        err_code;
  logic              full;

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, restart, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata, count, err, err_code, full
  );

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, restart, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, err, err_code, full
  );

endinterface

// File: rtl/inst_encoder_imm_pack.sv
// imm_pack: combinational RV32I packer and immediate checker.
//   fmt/opcode/rd/rs1/rs2/funct3/funct7/imm in -> 32-bit word and err_t out.
//   Priority of reported errors: BADFMT > MISALIGN > RANGE.
module imm_pack
  import enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output err_t        err
);

  // Scatter fields into the format's bit layout and classify the immediate.
  always_comb begin
    word = 32'h0000_0000;
    err  = ERR_NONE;
    case (fmt)
      FMT_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!upper_uniform(imm, 5'd11)) err = ERR_RANGE;
        else                            err = ERR_NONE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!upper_uniform(imm, 5'd11)) err = ERR_RANGE;
        else                            err = ERR_NONE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])                          err = ERR_MISALIGN;
        else if (!upper_uniform(imm, 5'd12)) err = ERR_RANGE;
        else                                 err = ERR_NONE;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        // Low 12 bits cannot be represented: the value is not 4 KiB aligned.
        if (imm[11:0] != 12'h000) err = ERR_MISALIGN;
        else                      err = ERR_NONE;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])                          err = ERR_MISALIGN;
        else if (!upper_uniform(imm, 5'd20)) err = ERR_RANGE;
        else                                 err = ERR_NONE;
      end
      default: begin
        word = 32'h0000_0000;
        err  = ERR_BADFMT;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts decoded instruction fields, packs/checks them and
// writes accepted words to consecutive instruction-memory addresses.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - inst_encoder_if.slave: request handshake, restart,
//                memory write/ack port, count/err/err_code/full status
// bus must be instantiated with the same ADDR_W as this module.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [2:0]        fmt_r;
  logic [6:0]        opcode_r;
  logic [4:0]        rd_r;
  logic [4:0]        rs1_r;
  logic [4:0]        rs2_r;
  logic [2:0]        funct3_r;
  logic [6:0]        funct7_r;
  logic [31:0]       imm_r;
  logic [31:0]       pack_word_s;
  err_t              pack_err_s;
  logic              mem_we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [ADDR_W:0]   count_r;
  logic              err_r;
  err_t              err_code_r;
  logic              full_r;
  logic              pend_r;
  logic              in_ready_s;
  logic              fire_s;
  logic              ack_s;
  logic              err_hit_s;
  logic              apply_rst_s;

  imm_pack u_pack (
    .fmt    (fmt_r),
    .opcode (opcode_r),
    .rd     (rd_r),
    .rs1    (rs1_r),
    .rs2    (rs2_r),
    .funct3 (funct3_r),
    .funct7 (funct7_r),
    .imm    (imm_r),
    .word   (pack_word_s),
    .err    (pack_err_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fire_s) state_nxt_s = ST_PACK;
        else        state_nxt_s = ST_IDLE;
      end
      ST_PACK: begin
        if (pack_err_s != ERR_NONE) state_nxt_s = ST_IDLE;
        else                        state_nxt_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.mem_ack) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_WRITE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: handshake, write completion, rejects, restart timing.
  // A restart seen outside IDLE is held back until the FSM re-enters IDLE so
  // the in-flight word still lands at its original address.
  always_comb begin
    in_ready_s = (state_r == ST_IDLE) && !full_r;
    fire_s     = bus.in_valid && in_ready_s;
    ack_s      = (state_r == ST_WRITE) && bus.mem_ack;
    err_hit_s  = (state_r == ST_PACK) && (pack_err_s != ERR_NONE);
    if (state_r == ST_IDLE) begin
      apply_rst_s = bus.restart;
    end else begin
      apply_rst_s = (state_nxt_s == ST_IDLE) && (pend_r || bus.restart);
    end
  end

  // Request field capture on fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmt_r    <= 3'd0;
      opcode_r <= 7'd0;
      rd_r     <= 5'd0;
      rs1_r    <= 5'd0;
      rs2_r    <= 5'd0;
      funct3_r <= 3'd0;
      funct7_r <= 7'd0;
      imm_r    <= 32'h0000_0000;
    end else if (fire_s) begin
      fmt_r    <= bus.in_fmt;
      opcode_r <= bus.in_opcode;
      rd_r     <= bus.in_rd;
      rs1_r    <= bus.in_rs1;
      rs2_r    <= bus.in_rs2;
      funct3_r <= bus.in_funct3;
      funct7_r <= bus.in_funct7;
      imm_r    <= bus.in_imm;
    end
  end

  // Memory write port: word captured in PACK, we held until the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r <= 1'b0;
      wdata_r  <= 32'h0000_0000;
    end else begin
      mem_we_r <= (state_nxt_s == ST_WRITE);
      if (state_r == ST_PACK) wdata_r <= pack_word_s;
    end
  end

  // Pending restart requested while a word is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    pend_r <= 1'b0;
    else if (apply_rst_s)                          pend_r <= 1'b0;
    else if (bus.restart && state_r != ST_IDLE)    pend_r <= 1'b1;
  end

  // Address, count and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= BASE;
      count_r    <= '0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      full_r     <= 1'b0;
    end else if (apply_rst_s) begin
      addr_r     <= BASE;
      count_r    <= '0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      full_r     <= 1'b0;
    end else begin
      if (ack_s) begin
        // Address wraps naturally; full keeps further requests out.
        addr_r  <= addr_r + ADDR_W'(1'b1);
        count_r <= count_r + (ADDR_W + 1)'(1'b1);
        if (addr_r == {ADDR_W{1'b1}}) full_r <= 1'b1;
      end
      if (err_hit_s) begin
        err_r <= 1'b1;
        if (err_code_r == ERR_NONE) err_code_r <= pack_err_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.count     = count_r;
  assign bus.err       = err_r;
  assign bus.err_code  = err_code_r;
  assign bus.full      = full_r;

endmodule
